hack_fetch_unit: RTL and testbench
==================================

Name: hack_fetch_unit

Overview:
Instruction fetch stage between the program counter and the Hack CPU decode and execute logic. Drives the read address of the synchronous instruction ROM, which has 1-cycle registered read latency and no enable. Captures the returned words into a 2-entry buffer and presents them to the CPU over a valid/ready handshake. Handles jump redirects by discarding in-flight and buffered words.

Parameters:
ADDR_WIDTH, 15, ROM address width (32K words).
WIDTH, 16, instruction word width.
RESET_VECTOR, 0, first fetch address after reset.

Ports:
i_CLK  input  1  system clock, all state on rising edge.
i_RST_N  input  1  asynchronous, active-low reset.
o_RomAddress  output  ADDR_WIDTH  ROM read address; equals the registered PC.
i_RomInstruction  input  WIDTH  ROM registered read data for the address presented at the previous edge.
i_Jump  input  1  redirect request, sampled on the rising edge.
i_JumpTarget  input  ADDR_WIDTH  redirect address, valid when i_Jump=1.
o_Instruction  output  WIDTH  instruction at buffer head.
o_InstrPC  output  ADDR_WIDTH  address of o_Instruction.
o_Valid  output  1  buffer head holds a valid instruction.
i_Ready  input  1  consumer accepts the head when o_Valid and i_Ready are both 1.

Behaviour:
- Reset (asynchronous, immediate):
  - r_PC = RESET_VECTOR.
  - Buffer count = 0, in-flight flag = 0.
  - o_Valid = 0, o_Instruction = 0, o_InstrPC = 0.
  - o_RomAddress = RESET_VECTOR.
- Pop: occurs when o_Valid and i_Ready are both 1 in a cycle.
- Issue: occurs in a cycle with no jump when (count + inflight - pop) < 2.
  - On that edge the ROM latches the current r_PC.
  - r_PC increments by 1, wrapping 2^ADDR_WIDTH-1 to 0.
  - The in-flight flag sets and r_InflightPC is set to the old r_PC.
- No issue: r_PC holds and the in-flight flag clears. The ROM still reads every cycle; those words are ignored.
- Capture: an edge with the in-flight flag set writes i_RomInstruction and r_InflightPC into the buffer tail.
  - Capture and pop on the same edge are both legal.
  - Credit accounting guarantees the buffer never overflows. Overflow is an assertion failure.
- Latency and throughput:
  - A word whose address is issued at edge E shows o_Valid=1 after edge E+1.
  - The first o_Valid=1 appears 2 edges after reset release.
  - With i_Ready held at 1, throughput is 1 instruction per cycle.
- Buffer: 2-entry FIFO.
  - o_Instruction and o_InstrPC come directly from the head register.
  - While o_Valid=1 and i_Ready=0, both must stay stable.
- Jump (i_Jump=1 at edge J):
  - A pop in the same cycle still completes; the consumer owns that word.
  - At J: buffer cleared, in-flight flag cleared, r_PC = i_JumpTarget. The ROM word latched at J is discarded.
  - J+1: target issued. J+2: target word is visible with o_Valid=1. This gives 2 bubble cycles.
  - Back-to-back jumps: the last one wins. Each jump restarts the sequence above.
  - Jump target 2^ADDR_WIDTH-1: fetch wraps to 0 afterwards.
- Reset asserted mid-stream: all state clears immediately, with no partial handshake. After release, fetch restarts at RESET_VECTOR.
- Arithmetic: PC increment is modulo 2^ADDR_WIDTH. Count is 2 bits, range 0..2.

Decomposition:
- Shared include file with the Hack constants HACK_ADDR_WIDTH=15, HACK_WORD_WIDTH=16 and HACK_RESET_VECTOR=0. The CPU and ROM use the same constants.
- One sub-module, hack_fetch_fifo:
  - 2-entry register FIFO of {PC, instruction}.
  - Ports: push, pop, flush, count, head outputs.
  - Asynchronous active-low reset.
- PC and credit logic stay in the top module.

Test Plan:
- Bench ROM model: 1-cycle registered read with contents mem[a] = a ^ 16'hA5A5.
- Reset release with i_Ready=1 -> o_Valid first high 2 cycles after release. Stream PC 0,1,2,3 with o_Instruction A5A5,A5A4,A5A7,A5A6, one per cycle, no gaps.
- i_Ready=0 for 5 cycles mid-stream at PC 4 -> count reaches 2 and issue stops. Head stays PC 4 / A5A1, stable. After i_Ready=1, PCs 4,5,6 arrive in order with no loss or duplicate.
- i_Jump=1, target 0x0100, while buffer holds PC 7,8 -> neither word is delivered. o_Valid=0 for 2 cycles, then PC 0x0100 / A4A5, then 0x0101.
- Jump in the same cycle as a pop of PC 10 -> PC 10 counts as consumed. Next delivered is the target 0x7FFF / DA5A, then 0x0000 / A5A5 (wrap).
- Reset asserted asynchronously between edges while o_Valid=1 -> o_Valid drops immediately and o_InstrPC=0. After release, the stream restarts at 0x0000.

Source files
------------

// File: rtl/hack_fetch_unit_pkg.sv
// Shared Hack machine constants and fetch-stage helpers.
// Used by the fetch unit, its buffer, and any block that shares the ROM geometry.
// Pure declarations: no clocked state, so no latency or backpressure.
package hack_fetch_unit_pkg;

  // Hack machine geometry, shared with the CPU core and the instruction ROM.
  localparam int unsigned HACK_ADDR_WIDTH   = 15;
  localparam int unsigned HACK_WORD_WIDTH   = 16;
  localparam int unsigned HACK_RESET_VECTOR = 0;

  // Depth of the fetch buffer. Credits in flight never exceed this.
  localparam int unsigned FETCH_DEPTH = 2;

  // True when one more ROM read can be started without risking buffer overflow.
  // Words that are buffered or in flight each hold one credit. A word popped
  // this cycle returns its credit right away.
  function automatic logic can_issue(input logic [1:0] count,
                                     input logic       inflight,
                                     input logic       pop);
    logic [2:0] occ;
    occ = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    return (occ < 3'(FETCH_DEPTH));
  endfunction

endpackage

// File: rtl/hack_fetch_fifo.sv
// Two-entry register FIFO of {pc, instruction}. The head is presented straight from a register.
// Latency: a push is visible at the head one edge later when the FIFO was empty.
// Backpressure: none internally. The producer must hold a credit. Flush has priority over push and pop.
module hack_fetch_fifo #(
  parameter int unsigned DW = 31
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] push_dat_i,
  input  logic          pop_i,
  output logic [1:0]    count_o,
  output logic          head_vld_o,
  output logic [DW-1:0] head_dat_o
);

  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic [1:0]    count_q, count_d;

  // Next-state for the two entries and the occupancy count.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      // Stored data is left alone. Only the count decides validity.
      count_d = 2'd0;
    end else begin
      unique case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_d  = push_dat_i;
            count_d = 2'd1;
          end else if (count_q == 2'd1) begin
            tail_d  = push_dat_i;
            count_d = 2'd2;
          end
        end
        2'b01: begin
          if (count_q != 2'd0) begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
          end
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            head_d = tail_q;
            tail_d = push_dat_i;
          end else begin
            // With one entry, the new word replaces the departing head.
            // With zero entries, the pop is void.
            head_d  = push_dat_i;
            count_d = 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage and count registers. Reset zeroes the head so outputs read 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign head_vld_o = (count_q != 2'd0);
  assign head_dat_o = head_q;

  // Credit accounting upstream must make these unreachable.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (push_i && !pop_i && !flush_i) |-> (count_q != 2'd2));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (pop_i && !flush_i) |-> (count_q != 2'd0));

endmodule

// File: rtl/hack_fetch_unit.sv
// Hack instruction fetch. Drives the ROM address, buffers returned words, and hands them to decode over valid/ready.
// Latency: 2 edges from issue to o_Valid. 2 bubble cycles after a jump. 1 instr/cycle when i_Ready is held high.
// Backpressure: i_Ready=0 stalls the head. Issue stops once buffered plus in-flight words fill both slots.
module hack_fetch_unit
  import hack_fetch_unit_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH   = HACK_ADDR_WIDTH,
  parameter int unsigned          WIDTH        = HACK_WORD_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(HACK_RESET_VECTOR)
) (
  input  logic                  i_CLK,
  input  logic                  i_RST_N,
  output logic [ADDR_WIDTH-1:0] o_RomAddress,
  input  logic [WIDTH-1:0]      i_RomInstruction,
  input  logic                  i_Jump,
  input  logic [ADDR_WIDTH-1:0] i_JumpTarget,
  output logic [WIDTH-1:0]      o_Instruction,
  output logic [ADDR_WIDTH-1:0] o_InstrPC,
  output logic                  o_Valid,
  input  logic                  i_Ready
);

  localparam int unsigned EW = ADDR_WIDTH + WIDTH;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                  inflight_q, inflight_d;

  logic       pop;
  logic       issue;
  logic       push;
  logic [1:0] buf_count;
  logic [EW-1:0] head_dat;

  // The consumer owns a popped word even when a jump lands on the same edge.
  assign pop   = o_Valid & i_Ready;
  assign issue = ~i_Jump & can_issue(buf_count, inflight_q, pop);
  // The ROM word that returns on a jump edge belongs to the old stream.
  assign push  = inflight_q & ~i_Jump;

  // PC and in-flight tracking. The ROM latches pc_q every edge, so the
  // in-flight flag records whether that read is one we asked for.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (i_Jump) begin
      pc_d = i_JumpTarget;
    end else if (issue) begin
      pc_d          = pc_q + 1'b1;
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end
  end

  // PC and in-flight state registers.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      pc_q          <= RESET_VECTOR;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  hack_fetch_fifo #(
    .DW (EW)
  ) u_fifo (
    .clk_i      (i_CLK),
    .rst_ni     (i_RST_N),
    .flush_i    (i_Jump),
    .push_i     (push),
    .push_dat_i ({inflight_pc_q, i_RomInstruction}),
    .pop_i      (pop),
    .count_o    (buf_count),
    .head_vld_o (o_Valid),
    .head_dat_o (head_dat)
  );

  assign o_RomAddress  = pc_q;
  assign o_InstrPC     = head_dat[EW-1:WIDTH];
  assign o_Instruction = head_dat[WIDTH-1:0];

endmodule

// File: tb/tb_hack_fetch_unit.sv
module tb_hack_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] rom_addr;
  logic [15:0] rom_q;
  logic        jump;
  logic [14:0] tgt;
  logic [15:0] instr;
  logic [14:0] ipc;
  logic        vld;
  logic        ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // ROM model: 1-cycle registered read, mem[a] = a ^ A5A5
  always @(posedge clk) rom_q <= 16'(rom_addr) ^ 16'hA5A5;

  hack_fetch_unit dut (
    .i_CLK            (clk),
    .i_RST_N          (rst_n),
    .o_RomAddress     (rom_addr),
    .i_RomInstruction (rom_q),
    .i_Jump           (jump),
    .i_JumpTarget     (tgt),
    .o_Instruction    (instr),
    .o_InstrPC        (ipc),
    .o_Valid          (vld),
    .i_Ready          (ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rdy;
    logic        jmp;
    logic [14:0] jtgt;
    logic        v;
    logic [14:0] pc;
    logic [15:0] ins;
    int          rom;   // -1 = do not check ROM address
  } vec_t;

  function automatic vec_t mk(input int r, input int j, input int t,
                              input int v, input int pc, input int ins, input int rom);
    vec_t e;
    e.rdy  = r[0];
    e.jmp  = j[0];
    e.jtgt = t[14:0];
    e.v    = v[0];
    e.pc   = pc[14:0];
    e.ins  = ins[15:0];
    e.rom  = rom;
    return e;
  endfunction

  vec_t tbl[28];

  // Reference model state: next PC the consumer should see, and edges since restart
  logic [14:0] exp_next;
  int          since;

  initial begin
    // Entry k: outputs expected after k edges, then inputs applied for the next edge
    tbl[0]  = mk(1, 0, 0,      0, 0,      0,       0);
    tbl[1]  = mk(1, 0, 0,      0, 0,      0,       -1);
    tbl[2]  = mk(1, 0, 0,      1, 0,      'hA5A5,  -1);
    tbl[3]  = mk(1, 0, 0,      1, 1,      'hA5A4,  3);
    tbl[4]  = mk(1, 0, 0,      1, 2,      'hA5A7,  -1);
    tbl[5]  = mk(1, 0, 0,      1, 3,      'hA5A6,  -1);
    tbl[6]  = mk(0, 0, 0,      1, 4,      'hA5A1,  -1);
    tbl[7]  = mk(0, 0, 0,      1, 4,      'hA5A1,  -1);
    tbl[8]  = mk(0, 0, 0,      1, 4,      'hA5A1,  -1);
    tbl[9]  = mk(0, 0, 0,      1, 4,      'hA5A1,  -1);
    tbl[10] = mk(0, 0, 0,      1, 4,      'hA5A1,  6);
    tbl[11] = mk(1, 0, 0,      1, 4,      'hA5A1,  -1);
    tbl[12] = mk(1, 0, 0,      1, 5,      'hA5A0,  -1);
    tbl[13] = mk(1, 0, 0,      1, 6,      'hA5A3,  -1);
    tbl[14] = mk(0, 0, 0,      1, 7,      'hA5A2,  -1);
    tbl[15] = mk(0, 1, 'h0100, 1, 7,      'hA5A2,  -1);
    tbl[16] = mk(1, 0, 0,      0, 0,      0,       -1);
    tbl[17] = mk(1, 0, 0,      0, 0,      0,       'h0101);
    tbl[18] = mk(1, 0, 0,      1, 'h0100, 'hA4A5,  -1);
    tbl[19] = mk(1, 1, 'h000A, 1, 'h0101, 'hA4A4,  -1);
    tbl[20] = mk(1, 0, 0,      0, 0,      0,       -1);
    tbl[21] = mk(1, 0, 0,      0, 0,      0,       -1);
    tbl[22] = mk(1, 1, 'h7FFF, 1, 'h000A, 'hA5AF,  -1);
    tbl[23] = mk(1, 0, 0,      0, 0,      0,       -1);
    tbl[24] = mk(1, 0, 0,      0, 0,      0,       -1);
    tbl[25] = mk(1, 0, 0,      1, 'h7FFF, 'hDA5A,  1);
    tbl[26] = mk(1, 0, 0,      1, 'h0000, 'hA5A5,  -1);
    tbl[27] = mk(1, 0, 0,      1, 'h0001, 'hA5A4,  -1);

    rst_n = 1'b0;
    ready = 1'b0;
    jump  = 1'b0;
    tgt   = '0;

    // Reset state
    #12;
    check("rst_valid", 32'(vld), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_ipc",   32'(ipc), 32'd0);
    check("rst_romad", 32'(rom_addr), 32'd0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 28; i++) begin
      check($sformatf("tbl%0d_valid", i), 32'(vld), 32'(tbl[i].v));
      if (tbl[i].v) begin
        check($sformatf("tbl%0d_pc", i),    32'(ipc),   32'(tbl[i].pc));
        check($sformatf("tbl%0d_instr", i), 32'(instr), 32'(tbl[i].ins));
      end
      if (tbl[i].rom >= 0)
        check($sformatf("tbl%0d_romaddr", i), 32'(rom_addr), 32'(tbl[i].rom));
      ready = tbl[i].rdy;
      jump  = tbl[i].jmp;
      tgt   = tbl[i].jtgt;
      step();
    end
    jump = 1'b0;

    // Asynchronous reset between edges while a word is valid
    check("pre_arst_valid", 32'(vld), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(vld), 32'd0);
    check("arst_ipc",   32'(ipc), 32'd0);
    check("arst_instr", 32'(instr), 32'd0);
    check("arst_romad", 32'(rom_addr), 32'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    exp_next = 15'd0;
    since    = 0;

    // Randomized run against the stream-level model:
    //  - valid is low for the two edges after a restart, and high afterwards
    //  - delivered PCs run consecutively (mod 2^15) from the restart address
    //  - each instruction equals its PC ^ A5A5
    for (int n = 0; n < 3000; n++) begin
      logic ev;
      logic pop;
      ev = (since >= 2);
      check("rnd_valid", 32'(vld), 32'(ev));
      if (ev) begin
        check("rnd_pc",    32'(ipc),   32'(exp_next));
        check("rnd_instr", 32'(instr), 32'(16'(exp_next) ^ 16'hA5A5));
      end
      if ($urandom_range(0, 599) == 0) begin
        jump = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rnd_arst_valid", 32'(vld), 32'd0);
        check("rnd_arst_ipc",   32'(ipc), 32'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        exp_next = 15'd0;
        since    = 0;
      end else begin
        ready = ($urandom_range(0, 9) < 7);
        jump  = ($urandom_range(0, 24) == 0);
        tgt   = ($urandom_range(0, 3) == 0) ? 15'h7FFF : 15'($urandom);
        pop   = ev && ready;
        step();
        if (jump) begin
          exp_next = tgt;
          since    = 0;
        end else begin
          if (pop) exp_next = exp_next + 15'd1;
          if (since < 2) since++;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
